// File: rtl/somador_serial_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// somador_serial_ctrl_pkg
// Shared definitions for the bit-serial adder sequencer:
//   state_e        : FSM encoding (IDLE=0, RUN=1, DONE=2) on SOMADOR_ST_W bits
//   cnt_width()    : bit-counter width, max(1, $clog2(width))
// -----------------------------------------------------------------------------
package somador_serial_ctrl_pkg;

   localparam int SOMADOR_ST_W = 2;

   typedef enum logic [SOMADOR_ST_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A single-bit operand still needs a 1-bit counter so the RUN->DONE
   // compare has something to look at.
   function automatic int cnt_width(input int width);
      int w;
      w = $clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/somador_serial_ctrl_somador.sv
// -----------------------------------------------------------------------------
// somador
// Purely combinational 1-bit full adder.
//   i0, i1 : operand bits
//   ci     : carry in
//   s      : sum bit
//   co     : carry out
// -----------------------------------------------------------------------------
module somador (
   input  logic i0,
   input  logic i1,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = i0 ^ i1 ^ ci;
   assign co = (i0 & i1) | (i0 & ci) | (i1 & ci);

endmodule

// File: rtl/somador_serial_ctrl.sv
// -----------------------------------------------------------------------------
// somador_serial_ctrl
// Bit-serial adder sequencer: adds two WIDTH-bit operands plus carry-in by
// pushing one bit pair per clock (LSB first) through a single full adder,
// recirculating the carry in a flop and assembling the sum in a shift register.
// One add takes WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE).
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, aborts any operation
//   start  : request, accepted only while ready=1
//   a, b   : operands, sampled on the accepting edge
//   cin    : carry-in, sampled on the accepting edge
//   ready  : 1 in IDLE
//   busy   : 1 in RUN
//   done   : one-cycle pulse in DONE, sum/cout valid from this cycle
//   sum    : (a+b+cin) mod 2^WIDTH, registered
//   cout   : carry out of the MSB, registered
// -----------------------------------------------------------------------------
module somador_serial_ctrl
   import somador_serial_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sha_q, sha_d;
   logic [WIDTH-1:0] shb_q, shb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] acc_shift;

   somador u_somador (
      .i0 (sha_q[0]),
      .i1 (shb_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts the LSB
   // computed first has reached bit 0. Written as shift-then-overwrite so
   // it also holds for WIDTH=1.
   always_comb begin
      acc_shift            = acc_q >> 1;
      acc_shift[WIDTH-1]   = fa_s;
   end

   always_comb begin
      state_d = state_q;
      sha_d   = sha_q;
      shb_d   = shb_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               sha_d   = a;
               shb_d   = b;
               carry_d = cin;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            sha_d   = sha_q >> 1;
            shb_d   = shb_q >> 1;
            carry_d = fa_co;
            acc_d   = acc_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               // Publish only the finished result; sum never shows partials.
               state_d = ST_DONE;
               sum_d   = acc_shift;
               cout_d  = fa_co;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status flags are registered copies of the next-state decode, so they
      // line up with state_q and stay mutually exclusive.
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d == ST_RUN);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sha_q   <= sha_d;
         shb_q   <= shb_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign cout  = cout_q;

endmodule

// File: tb/tb_somador_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_somador_serial_ctrl
// Directed and table-driven bench for the bit-serial adder sequencer, WIDTH=8.
// -----------------------------------------------------------------------------
module tb_somador_serial_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int n_tests = 0;
   int n_fail  = 0;

   somador_serial_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vc;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Starts an add from IDLE with a one-cycle start pulse, scrambles the
   // operand inputs during RUN, and checks the exact WIDTH+1 latency.
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic [W-1:0] es, input logic ec, input string tag,
                        input bit detail);
      logic [W-1:0] prev;
      logic         prev_c;
      prev   = sum;
      prev_c = cout;
      check({tag, " ready before start"}, ready, 1);
      a = ia; b = ib; cin = ic; start = 1'b1;
      tick();
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      for (int i = 1; i <= W; i++) begin
         if (detail) begin
            check($sformatf("%s busy c%0d", tag, i), busy, 1);
            check($sformatf("%s done c%0d", tag, i), done, 0);
            check($sformatf("%s sum held c%0d", tag, i), {prev_c, prev}, {cout, sum});
         end
         tick();
      end
      check({tag, " done"}, done, 1);
      check({tag, " sum"}, sum, es);
      check({tag, " cout"}, cout, ec);
      check({tag, " busy in done"}, busy, 0);
      tick();
      check({tag, " ready after"}, ready, 1);
      check({tag, " done cleared"}, done, 0);
      check({tag, " sum held idle"}, sum, es);
   endtask

   initial begin
      vecs[0]  = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
      vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[6]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      vecs[7]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      vecs[8]  = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
      vecs[9]  = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0};
      vecs[10] = '{8'h64, 8'h9C, 1'b0, 8'h00, 1'b1};
      vecs[11] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

      // Reset
      tick();
      tick();
      rst = 1'b0;
      check("reset ready", ready, 1);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sum", sum, 0);
      check("reset cout", cout, 0);

      // Detailed first add, then the table
      do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, "basic", 1'b1);
      for (int i = 0; i < 12; i++)
         do_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].exp_sum, vecs[i].exp_cout,
               $sformatf("vec%0d", i), 1'b0);

      // start held high, operands changed during RUN, start high in DONE
      a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
      tick();
      a = 8'h01; b = 8'h01;
      for (int i = 1; i <= W; i++) begin
         check($sformatf("hold ready c%0d", i), ready, 0);
         tick();
      end
      check("hold done", done, 1);
      check("hold sum", sum, 8'h7F);
      check("hold cout", cout, 0);
      tick();
      check("hold idle after done", ready, 1);
      check("hold not busy", busy, 0);
      tick();
      check("hold reaccepted", busy, 1);
      start = 1'b0;
      for (int i = 2; i <= W; i++) tick();
      tick();
      check("hold second done", done, 1);
      check("hold second sum", sum, 8'h02);
      tick();

      // Reset mid-RUN aborts with no done pulse and clears the result
      a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 4; i++) tick();
      check("abort busy c4", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort ready", ready, 1);
      check("abort busy", busy, 0);
      check("abort sum", sum, 0);
      check("abort cout", cout, 0);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 12; i++) begin
            seen = seen | done;
            tick();
         end
         check("abort no done", seen, 0);
      end
      do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "after abort", 1'b1);

      // Random sweep against an arithmetic reference
      for (int i = 0; i < 300; i++) begin
         logic [W-1:0] ra, rb;
         logic         rc;
         logic [W:0]   ref_v;
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         do_op(ra, rb, rc, ref_v[W-1:0], ref_v[W], $sformatf("rnd%0d", i), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
